// File: rtl/ooo_read_responder_pkg.sv
// Shared constants for the out-of-order read responder.
package ooo_resp_pkg;

    localparam int unsigned ID_WIDTH = 4;
    localparam int unsigned NUM_IDS  = 16;

endpackage

// File: rtl/ooo_read_responder_if.sv
// AR request / R response channel between a read master and the responder.
interface ooo_read_responder_if
    import ooo_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
);

    logic [ID_WIDTH-1:0]   s_arid_i;
    logic                  s_arvalid_i;
    logic                  s_arready_o;
    logic [DATA_WIDTH-1:0] s_rdata_o;
    logic [ID_WIDTH-1:0]   s_rid_o;
    logic                  s_rvalid_o;
    logic                  s_rready_i;

    modport master (
        output s_arid_i, s_arvalid_i, s_rready_i,
        input  s_arready_o, s_rdata_o, s_rid_o, s_rvalid_o
    );

    modport slave (
        input  s_arid_i, s_arvalid_i, s_rready_i,
        output s_arready_o, s_rdata_o, s_rid_o, s_rvalid_o
    );

endinterface

// File: rtl/ooo_read_responder_lowest_set_idx.sv
// Priority encoder: index of the lowest set bit, plus a found flag.
module lowest_set_idx #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ooo_read_responder.sv
// Read target returning R beats in completion order with per-ID latency.
module ooo_read_responder
    import ooo_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned LAT_WIDTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IDS*LAT_WIDTH-1:0] cfg_lat_i,
    ooo_read_responder_if.slave          bus
);

    localparam int unsigned SLOT_W = $clog2(DEPTH);

    logic [DEPTH-1:0]      slot_valid;
    logic [ID_WIDTH-1:0]   slot_id   [DEPTH];
    logic [DATA_WIDTH-1:0] slot_data [DEPTH];
    logic [LAT_WIDTH-1:0]  slot_cnt  [DEPTH];
    logic [DATA_WIDTH-1:0] seq;

    logic [DEPTH-1:0]      free_vec;
    logic [DEPTH-1:0]      elig_vec;
    logic [SLOT_W-1:0]     free_idx;
    logic [SLOT_W-1:0]     elig_idx;
    logic                  free_found;
    logic                  elig_found;
    logic                  id_hit;
    logic                  ar_fire;
    logic                  r_load;
    logic [LAT_WIDTH-1:0]  req_lat;

    // Per-slot free / eligible flags and duplicate-ID detection on current state.
    always_comb begin
        free_vec = '0;
        elig_vec = '0;
        id_hit   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            free_vec[i] = !slot_valid[i];
            elig_vec[i] = slot_valid[i] && (slot_cnt[i] == '0);
            if (slot_valid[i] && (slot_id[i] == bus.s_arid_i)) begin
                id_hit = 1'b1;
            end
        end
    end

    lowest_set_idx #(.WIDTH(DEPTH), .IDX_W(SLOT_W)) u_free_sel (
        .vec   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    lowest_set_idx #(.WIDTH(DEPTH), .IDX_W(SLOT_W)) u_elig_sel (
        .vec   (elig_vec),
        .idx   (elig_idx),
        .found (elig_found)
    );

    assign bus.s_arready_o = free_found && !id_hit;
    assign ar_fire         = bus.s_arvalid_i && bus.s_arready_o;
    assign r_load          = (!bus.s_rvalid_o || bus.s_rready_i) && elig_found;
    assign req_lat         = cfg_lat_i[int'(bus.s_arid_i) * LAT_WIDTH +: LAT_WIDTH];

    // Slot table: countdown, release on load into the output register, allocate on AR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_id[i]   <= '0;
                slot_data[i] <= '0;
                slot_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_valid[i] && (slot_cnt[i] != '0)) begin
                    slot_cnt[i] <= slot_cnt[i] - LAT_WIDTH'(1);
                end
                if (r_load && (elig_idx == SLOT_W'(i))) begin
                    slot_valid[i] <= 1'b0;
                end
                if (ar_fire && (free_idx == SLOT_W'(i))) begin
                    slot_valid[i] <= 1'b1;
                    slot_id[i]    <= bus.s_arid_i;
                    slot_data[i]  <= seq;
                    slot_cnt[i]   <= req_lat;
                end
            end
        end
    end

    // Request sequence number, used as the returned data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq <= '0;
        end else if (ar_fire) begin
            seq <= seq + DATA_WIDTH'(1);
        end
    end

    // Single-entry R output register; payload holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.s_rvalid_o <= 1'b0;
            bus.s_rid_o    <= '0;
            bus.s_rdata_o  <= '0;
        end else if (r_load) begin
            bus.s_rvalid_o <= 1'b1;
            bus.s_rid_o    <= slot_id[elig_idx];
            bus.s_rdata_o  <= slot_data[elig_idx];
        end else if (bus.s_rready_i) begin
            bus.s_rvalid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ooo_read_responder.sv
// Self-checking bench for ooo_read_responder: directed scenarios plus random traffic vs a timestamp model.
module tb_ooo_read_responder;
    import ooo_resp_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_IDS*LW-1:0] cfg_lat;

    ooo_read_responder_if #(.DATA_WIDTH(DW)) bus ();

    ooo_read_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LAT_WIDTH(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_lat_i (cfg_lat),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int nchk  = 0;
    int npass = 0;

    // Reference model: slots carry the absolute cycle at which they become eligible.
    logic          m_valid [DEPTH];
    logic [3:0]    m_id    [DEPTH];
    logic [7:0]    m_data  [DEPTH];
    longint        m_elig  [DEPTH];
    logic          m_rvalid;
    logic [3:0]    m_rid;
    logic [7:0]    m_rdata;
    logic [7:0]    m_seq;
    longint        mcyc;
    logic          m_ardy;

    logic          n_valid [DEPTH];
    logic [3:0]    n_id    [DEPTH];
    logic [7:0]    n_data  [DEPTH];
    longint        n_elig  [DEPTH];
    logic          n_rvalid;
    logic [3:0]    n_rid;
    logic [7:0]    n_rdata;

    always_comb begin
        int f;
        int e;
        logic any_free;
        logic hit;
        n_valid  = m_valid;
        n_id     = m_id;
        n_data   = m_data;
        n_elig   = m_elig;
        n_rvalid = m_rvalid;
        n_rid    = m_rid;
        n_rdata  = m_rdata;
        f        = -1;
        e        = -1;
        any_free = 1'b0;
        hit      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!m_valid[i]) any_free = 1'b1;
            if (m_valid[i] && m_id[i] == bus.s_arid_i) hit = 1'b1;
            if (!m_valid[i] && f < 0) f = i;
            if (m_valid[i] && mcyc >= m_elig[i] && e < 0) e = i;
        end
        m_ardy = any_free && !hit;
        if ((!m_rvalid || bus.s_rready_i) && e >= 0) begin
            n_rvalid   = 1'b1;
            n_rid      = m_id[e];
            n_rdata    = m_data[e];
            n_valid[e] = 1'b0;
        end else if (bus.s_rready_i && m_rvalid) begin
            n_rvalid = 1'b0;
        end
        if (bus.s_arvalid_i && m_ardy && f >= 0) begin
            n_valid[f] = 1'b1;
            n_id[f]    = bus.s_arid_i;
            n_data[f]  = m_seq;
            n_elig[f]  = mcyc + 1 + longint'(cfg_lat[int'(bus.s_arid_i) * 4 +: 4]);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[i] <= 1'b0;
                m_id[i]    <= 4'd0;
                m_data[i]  <= 8'd0;
                m_elig[i]  <= 0;
            end
            m_rvalid <= 1'b0;
            m_rid    <= 4'd0;
            m_rdata  <= 8'd0;
            m_seq    <= 8'd0;
            mcyc     <= 0;
        end else begin
            m_valid  <= n_valid;
            m_id     <= n_id;
            m_data   <= n_data;
            m_elig   <= n_elig;
            m_rvalid <= n_rvalid;
            m_rid    <= n_rid;
            m_rdata  <= n_rdata;
            if (bus.s_arvalid_i && m_ardy) m_seq <= m_seq + 8'd1;
            mcyc     <= mcyc + 1;
        end
    end

    task automatic idle();
        bus.s_arvalid_i = 1'b0;
        bus.s_arid_i    = 4'd0;
        bus.s_rready_i  = 1'b1;
    endtask

    task automatic set_lat(input int id, input int lat);
        cfg_lat[id*4 +: 4] = 4'(lat);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cfg_lat = '0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Hold an AR until accepted; waited = cycles with arready low, -1 on timeout.
    task automatic send_ar(input logic [3:0] id, output int waited);
        bus.s_arvalid_i = 1'b1;
        bus.s_arid_i    = id;
        waited          = 0;
        while (waited >= 0) begin
            @(negedge clk);
            if (bus.s_arready_o === 1'b1) break;
            waited++;
            if (waited > 200) waited = -1;
        end
        @(posedge clk);
        #1;
        bus.s_arvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        int w;
        int wsum;
        logic stale;
        rst = 1'b1;
        idle();
        cfg_lat = '0;
        @(negedge clk);
        nchk++; if (bus.s_arready_o !== 1'b1) $display("FAIL rst_arready: got %b expected 1", bus.s_arready_o); else npass++;
        nchk++; if (bus.s_rvalid_o !== 1'b0) $display("FAIL rst_rvalid: got %b expected 0", bus.s_rvalid_o); else npass++;
        nchk++; if (bus.s_rid_o !== 4'd0) $display("FAIL rst_rid: got %0d expected 0", bus.s_rid_o); else npass++;
        nchk++; if (bus.s_rdata_o !== 8'd0) $display("FAIL rst_rdata: got %0d expected 0", bus.s_rdata_o); else npass++;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        set_lat(0, 0); set_lat(1, 15); set_lat(2, 15); set_lat(3, 15);
        bus.s_rready_i = 1'b0;
        wsum = 0;
        send_ar(4'd1, w); wsum += w;
        send_ar(4'd0, w); wsum += w;
        send_ar(4'd2, w); wsum += w;
        send_ar(4'd3, w); wsum += w;
        nchk++; if (wsum !== 0) $display("FAIL rst_setup_waits: got %0d expected 0", wsum); else npass++;
        @(negedge clk);
        nchk++; if (bus.s_rvalid_o !== 1'b1 || bus.s_rid_o !== 4'd0 || bus.s_rdata_o !== 8'd1)
            $display("FAIL rst_pending: got v=%b id=%0d d=%0d expected v=1 id=0 d=1", bus.s_rvalid_o, bus.s_rid_o, bus.s_rdata_o);
        else npass++;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        nchk++; if (bus.s_rvalid_o !== 1'b0) $display("FAIL rst_async_rvalid: got %b expected 0", bus.s_rvalid_o); else npass++;
        nchk++; if (bus.s_rid_o !== 4'd0) $display("FAIL rst_async_rid: got %0d expected 0", bus.s_rid_o); else npass++;
        nchk++; if (bus.s_rdata_o !== 8'd0) $display("FAIL rst_async_rdata: got %0d expected 0", bus.s_rdata_o); else npass++;
        nchk++; if (bus.s_arready_o !== 1'b1) $display("FAIL rst_async_arready: got %b expected 1", bus.s_arready_o); else npass++;
        @(posedge clk);
        #3 rst = 1'b0;
        bus.s_rready_i = 1'b1;
        stale = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.s_rvalid_o !== 1'b0) stale = 1'b1;
        end
        nchk++; if (stale !== 1'b0) $display("FAIL rst_stale_resp: got %b expected 0", stale); else npass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        int w;
        int n;
        logic got;
        do_reset();
        set_lat(2, 3);
        send_ar(4'd2, w);
        nchk++; if (w !== 0) $display("FAIL lat_accept_wait: got %0d expected 0", w); else npass++;
        n = 0;
        got = 1'b0;
        while (n < 30 && !got) begin
            @(negedge clk);
            n++;
            if (bus.s_rvalid_o === 1'b1) got = 1'b1;
        end
        nchk++; if (n !== 5) $display("FAIL lat_cycles: got %0d expected 5", n); else npass++;
        nchk++; if (bus.s_rid_o !== 4'd2) $display("FAIL lat_rid: got %0d expected 2", bus.s_rid_o); else npass++;
        nchk++; if (bus.s_rdata_o !== 8'd0) $display("FAIL lat_rdata: got %0d expected 0", bus.s_rdata_o); else npass++;
        @(negedge clk);
        nchk++; if (bus.s_rvalid_o !== 1'b0) $display("FAIL lat_single_beat: got %b expected 0", bus.s_rvalid_o); else npass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reorder();
        int w1;
        int w2;
        int cnt;
        logic [3:0] rid [2];
        logic [7:0] rdat [2];
        do_reset();
        set_lat(1, 6);
        set_lat(5, 0);
        send_ar(4'd1, w1);
        send_ar(4'd5, w2);
        nchk++; if (w1 !== 0 || w2 !== 0) $display("FAIL ord_waits: got %0d,%0d expected 0,0", w1, w2); else npass++;
        cnt = 0;
        rid[0] = 4'hf; rid[1] = 4'hf; rdat[0] = 8'hff; rdat[1] = 8'hff;
        for (int c = 0; c < 40 && cnt < 2; c++) begin
            @(negedge clk);
            if (bus.s_rvalid_o === 1'b1) begin
                rid[cnt]  = bus.s_rid_o;
                rdat[cnt] = bus.s_rdata_o;
                cnt++;
            end
        end
        nchk++; if (cnt !== 2) $display("FAIL ord_count: got %0d expected 2", cnt); else npass++;
        nchk++; if (rid[0] !== 4'd5 || rdat[0] !== 8'd1) $display("FAIL ord_first: got id=%0d d=%0d expected id=5 d=1", rid[0], rdat[0]); else npass++;
        nchk++; if (rid[1] !== 4'd1 || rdat[1] !== 8'd0) $display("FAIL ord_second: got id=%0d d=%0d expected id=1 d=0", rid[1], rdat[1]); else npass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int w;
        int n;
        logic stable;
        do_reset();
        set_lat(3, 2);
        set_lat(6, 1);
        bus.s_rready_i = 1'b0;
        send_ar(4'd3, w);
        send_ar(4'd6, w);
        n = 0;
        while (n < 20 && bus.s_rvalid_o !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        nchk++; if (bus.s_rvalid_o !== 1'b1 || bus.s_rid_o !== 4'd3 || bus.s_rdata_o !== 8'd0)
            $display("FAIL bp_first: got v=%b id=%0d d=%0d expected v=1 id=3 d=0", bus.s_rvalid_o, bus.s_rid_o, bus.s_rdata_o);
        else npass++;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.s_rvalid_o !== 1'b1 || bus.s_rid_o !== 4'd3 || bus.s_rdata_o !== 8'd0) stable = 1'b0;
        end
        nchk++; if (stable !== 1'b1) $display("FAIL bp_stable: got %b expected 1", stable); else npass++;
        @(posedge clk);
        #1 bus.s_rready_i = 1'b1;
        @(negedge clk);
        nchk++; if (bus.s_rvalid_o !== 1'b1 || bus.s_rid_o !== 4'd3)
            $display("FAIL bp_handshake: got v=%b id=%0d expected v=1 id=3", bus.s_rvalid_o, bus.s_rid_o);
        else npass++;
        @(negedge clk);
        nchk++; if (bus.s_rvalid_o !== 1'b1 || bus.s_rid_o !== 4'd6 || bus.s_rdata_o !== 8'd1)
            $display("FAIL bp_next: got v=%b id=%0d d=%0d expected v=1 id=6 d=1", bus.s_rvalid_o, bus.s_rid_o, bus.s_rdata_o);
        else npass++;
        @(negedge clk);
        nchk++; if (bus.s_rvalid_o !== 1'b0) $display("FAIL bp_drain: got %b expected 0", bus.s_rvalid_o); else npass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_dup_full();
        int w;
        int wsum;
        do_reset();
        set_lat(4, 5);
        send_ar(4'd4, w);
        nchk++; if (w !== 0) $display("FAIL dup_first_wait: got %0d expected 0", w); else npass++;
        send_ar(4'd4, w);
        nchk++; if (w !== 6) $display("FAIL dup_blocked_cycles: got %0d expected 6", w); else npass++;
        do_reset();
        for (int i = 8; i <= 12; i++) set_lat(i, 15);
        wsum = 0;
        for (int i = 8; i <= 11; i++) begin
            send_ar(4'(i), w);
            wsum += w;
        end
        nchk++; if (wsum !== 0) $display("FAIL full_fill_waits: got %0d expected 0", wsum); else npass++;
        send_ar(4'd12, w);
        nchk++; if (w !== 13) $display("FAIL full_blocked_cycles: got %0d expected 13", w); else npass++;
        @(negedge clk);
        nchk++; if (bus.s_rvalid_o !== 1'b1 || bus.s_rid_o !== 4'd9 || bus.s_rdata_o !== 8'd1)
            $display("FAIL full_second_resp: got v=%b id=%0d d=%0d expected v=1 id=9 d=1", bus.s_rvalid_o, bus.s_rid_o, bus.s_rdata_o);
        else npass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_seq_wrap();
        int bad_wait;
        int cnt;
        int cyc;
        logic [7:0] last_d;
        do_reset();
        bad_wait = 0;
        cnt      = 0;
        cyc      = 0;
        last_d   = 8'hff;
        fork
            begin
                int w;
                for (int i = 0; i < 257; i++) begin
                    send_ar(4'(i % 16), w);
                    if (w != 0) bad_wait++;
                end
            end
            begin
                while (cnt < 257 && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                    if (bus.s_rvalid_o === 1'b1) begin
                        nchk++;
                        if (bus.s_rdata_o !== 8'(cnt) || bus.s_rid_o !== 4'(cnt % 16))
                            $display("FAIL wrap_beat%0d: got id=%0d d=%0d expected id=%0d d=%0d",
                                     cnt, bus.s_rid_o, bus.s_rdata_o, cnt % 16, cnt % 256);
                        else npass++;
                        if (cnt == 256) last_d = bus.s_rdata_o;
                        cnt++;
                    end
                end
            end
        join
        nchk++; if (cnt !== 257) $display("FAIL wrap_count: got %0d expected 257", cnt); else npass++;
        nchk++; if (last_d !== 8'd0) $display("FAIL wrap_last: got %0d expected 0", last_d); else npass++;
        nchk++; if (bad_wait !== 0) $display("FAIL wrap_ar_stalls: got %0d expected 0", bad_wait); else npass++;
        nchk++; if (cyc > 262) $display("FAIL wrap_throughput: got %0d cycles expected <= 262", cyc); else npass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < NUM_IDS; i++) set_lat(i, int'($urandom_range(7, 0)));
        for (int c = 0; c < 600; c++) begin
            bus.s_arvalid_i = 1'($urandom_range(1, 0));
            bus.s_arid_i    = 4'($urandom_range(7, 0));
            bus.s_rready_i  = ($urandom_range(3, 0) != 0);
            @(negedge clk);
            nchk++; if (bus.s_arready_o !== m_ardy) $display("FAIL rnd_arready c%0d: got %b expected %b", c, bus.s_arready_o, m_ardy); else npass++;
            nchk++; if (bus.s_rvalid_o !== m_rvalid) $display("FAIL rnd_rvalid c%0d: got %b expected %b", c, bus.s_rvalid_o, m_rvalid); else npass++;
            if (m_rvalid) begin
                nchk++; if (bus.s_rid_o !== m_rid || bus.s_rdata_o !== m_rdata)
                    $display("FAIL rnd_payload c%0d: got id=%0d d=%0d expected id=%0d d=%0d", c, bus.s_rid_o, bus.s_rdata_o, m_rid, m_rdata);
                else npass++;
            end
            @(posedge clk);
            #1;
        end
        idle();
    endtask

    initial begin
        rst     = 1'b1;
        cfg_lat = '0;
        idle();
        test_reset();
        test_latency();
        test_reorder();
        test_backpressure();
        test_dup_full();
        test_seq_wrap();
        test_random();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/ooo_read_responder.md
# ooo_read_responder

Out-of-order read responder that sits directly downstream of the reorder buffer's master side: it accepts its AR requests and returns R beats in completion order, not request order. Each request gets a per-ID programmable latency, so the responder is both the synthesizable memory-side model for the reorder buffer bench and a reusable AXI-like read target. At most one request per ID is outstanding, which matches the buffer's one-entry-per-ID storage.

## Interface
- DATA_WIDTH, 8, R data width
- DEPTH, 4, number of outstanding-request slots (2..16)
- LAT_WIDTH, 4, width of each per-ID latency field
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_lat_i  in  16*LAT_WIDTH  latency for ID n in bits [n*LAT_WIDTH +: LAT_WIDTH]; sampled at AR acceptance
- s_arid_i  in  4  request ID
- s_arvalid_i  in  1  request valid
- s_arready_o  out  1  request accepted when high with s_arvalid_i
- s_rdata_o  out  DATA_WIDTH  response data
- s_rid_o  out  4  response ID
- s_rvalid_o  out  1  response valid
- s_rready_i  in  1  response consumed when high with s_rvalid_o

## Operation
- Slot state per entry: valid, id[3:0], data[DATA_WIDTH-1:0], cnt[LAT_WIDTH-1:0].
- seq counter: DATA_WIDTH bits, reset 0, increments on every AR handshake, wraps modulo 2^DATA_WIDTH.
- s_arready_o = (any slot free) && !(any valid slot has id == s_arid_i). Combinational from current state only; slots freed this cycle do not count.
- AR handshake: the lowest-index free slot loads valid=1, id=s_arid_i, data=seq (pre-increment value), cnt=cfg_lat_i[s_arid_i].
- Every cycle, each valid slot with cnt>0 decrements by 1. No underflow: cnt==0 holds.
- Eligible slot: valid && cnt==0.
- Output register load condition: (!s_rvalid_o || s_rready_i) && any eligible slot.
  - On load: the lowest-index eligible slot is copied to s_rid_o/s_rdata_o, s_rvalid_o=1, and the slot is cleared.
  - Otherwise, if s_rready_i && s_rvalid_o, then s_rvalid_o=0. s_rid_o/s_rdata_o keep their values.
- While s_rvalid_o is high and s_rready_i is low, s_rid_o/s_rdata_o are stable.
- Allocation and load in the same cycle use different slots by construction: the allocated slot was free, the loaded slot was valid.
- Once an ID moves into the output register, its slot is free. A new request with that ID can then be accepted; ordering is still kept because the output register is single-entry.

## Timing
- Reset values: s_arready_o=1 (combinational, all slots free), s_rvalid_o=0, s_rid_o=0, s_rdata_o=0, all slots invalid, seq=0.
- Reset asserted mid-operation: outstanding requests are dropped and the outputs return to their reset values immediately (async).
- AR accepted in cycle T with latency L:
  - slot becomes valid in T+1 with cnt=L;
  - slot is eligible in T+1+L;
  - s_rvalid_o rises in T+2+L at the earliest (later if the output register is blocked or a lower-index slot wins).
- Throughput: one response per cycle when s_rready_i is held high and slots are eligible back-to-back.
- Full (DEPTH valid slots): s_arready_o=0 until the cycle after a slot is loaded into the output register.

## Structure
- Package ooo_resp_pkg holds:
  - ID_WIDTH=4, NUM_IDS=16;
  - a parameterized slot struct typedef (valid, id, data, cnt), or, if the tool lacks parameterized-struct support, separate per-field arrays sized from the package constants.
- Sub-module lowest_set_idx: parameterized lowest-index priority encoder (vector in, index out, found flag). Instantiated twice: once for free-slot selection, once for eligible-slot selection.

## Test plan
- Reset: assert rst mid-stream with 3 requests pending -> s_rvalid_o=0, s_rid_o=0, s_rdata_o=0 immediately, s_arready_o=1; no stale response after release.
- Latency: cfg_lat ID2=3, AR id 2 accepted at cycle 10, rready=1 -> s_rvalid_o first high in cycle 15 with rid=2, rdata=0.
- Reordering: cfg ID1=6, ID5=0; AR id1 then id5 on consecutive cycles -> id5 (rdata=1) returned before id1 (rdata=0).
- Backpressure: rready=0 for 5 cycles with response id3 pending -> rvalid, rid, rdata stable; the next eligible response is delivered the cycle after rready=1.
- Duplicate ID and full: AR id4 while id4 is outstanding -> s_arready_o=0 until id4 leaves its slot. DEPTH=4 requests with latency 15 -> arready=0 on the 5th request until the first response is loaded.
- Seq wrap: 257 sequential requests with latency 0, DATA_WIDTH=8 -> rdata sequence 0..255 followed by 0.
